// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  localparam int LINE_BEATS = 4;

  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEAT_CNT_W = beat_cnt_w(LINE_BEATS);

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker; last_grant only moves on an accepted request,
// so the pick stays stable while memory stalls the request.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ic_valid,
  input  logic dc_valid,
  input  logic grant_fire,
  output logic pick_dc
);

  req_id_t last_grant_reg;
  req_id_t pick;

  always_comb begin
    pick = REQ_IC;
    if (dc_valid && (!ic_valid || last_grant_reg == REQ_IC)) begin
      pick = REQ_DC;
    end
  end

  // Reset value makes the first tie go to the icache.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= REQ_DC;
    end else if (grant_fire) begin
      last_grant_reg <= pick;
    end
  end

  assign pick_dc = (pick == REQ_DC);

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: icache refills vs dcache refills/writebacks,
// one line transaction (request + BEATS beats) at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int BEATS  = LINE_BEATS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_data_valid,
  output logic              dc_req_data_ready,
  input  logic [DATA_W-1:0] dc_req_data_bits,
  input  logic [MASK_W-1:0] dc_req_data_mask,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_data_valid,
  input  logic              mem_req_data_ready,
  output logic [DATA_W-1:0] mem_req_data_bits,
  output logic [MASK_W-1:0] mem_req_data_mask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam int CNT_W = beat_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           state_reg;
  req_id_t          owner_reg;
  logic [CNT_W-1:0] beat_cnt_reg;

  logic    pick_dc;
  req_id_t winner;
  logic    in_idle, in_rd, in_wr;
  logic    grant_fire, wr_fire, beat_step;
  logic [1:0] resp_valid_vec;

  mem_arb_rr_pick u_pick (
    .clk        (clk),
    .reset      (reset),
    .ic_valid   (ic_req_valid),
    .dc_valid   (dc_req_valid),
    .grant_fire (grant_fire),
    .pick_dc    (pick_dc)
  );

  // Reset gates every handshake output so nothing escapes while resetting.
  assign in_idle = (state_reg == IDLE) && !reset;
  assign in_rd   = (state_reg == RD) && !reset;
  assign in_wr   = (state_reg == WR) && !reset;
  assign busy    = (state_reg != IDLE) && !reset;

  assign winner        = pick_dc ? REQ_DC : REQ_IC;
  assign mem_req_valid = in_idle && (ic_req_valid || dc_req_valid);
  assign mem_req_addr  = (winner == REQ_DC) ? dc_req_addr : ic_req_addr;
  assign mem_req_rw    = (winner == REQ_DC) && dc_req_rw;
  assign grant_fire    = mem_req_valid && mem_req_ready;

  assign ic_req_ready = in_idle && ic_req_valid && (winner == REQ_IC) && mem_req_ready;
  assign dc_req_ready = in_idle && dc_req_valid && (winner == REQ_DC) && mem_req_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign resp_valid_vec[gi] = in_rd && mem_resp_valid && (owner_reg == req_id_t'(gi));
  end

  assign ic_resp_valid = resp_valid_vec[REQ_IC];
  assign dc_resp_valid = resp_valid_vec[REQ_DC];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  assign mem_req_data_valid = in_wr && dc_req_data_valid;
  assign dc_req_data_ready  = in_wr && mem_req_data_ready;
  assign mem_req_data_bits  = dc_req_data_bits;
  assign mem_req_data_mask  = dc_req_data_mask;

  assign wr_fire   = in_wr && dc_req_data_valid && mem_req_data_ready;
  assign beat_step = (in_rd && mem_resp_valid) || wr_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= REQ_IC;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            owner_reg    <= winner;
            beat_cnt_reg <= '0;
            state_reg    <= mem_req_rw ? WR : RD;
          end
        end
        RD, WR: begin
          if (beat_step) begin
            if (beat_cnt_reg == LAST_BEAT) begin
              beat_cnt_reg <= '0;
              state_reg    <= IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ic_req_valid = 0, ic_req_ready;
  logic [27:0]  ic_req_addr = '0;
  logic         ic_resp_valid;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid = 0, dc_req_ready, dc_req_rw = 0;
  logic [27:0]  dc_req_addr = '0;
  logic         dc_req_data_valid = 0, dc_req_data_ready;
  logic [127:0] dc_req_data_bits = '0;
  logic [15:0]  dc_req_data_mask = '0;
  logic         dc_resp_valid;
  logic [127:0] dc_resp_data;
  logic         mem_req_valid, mem_req_ready = 0, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_req_data_valid, mem_req_data_ready = 0;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid = 0;
  logic [127:0] mem_resp_data = '0;
  logic         busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
    .dc_resp_data(dc_resp_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 = no transaction, 1 = line read, 2 = line write.
  int m_phase = 0;
  int m_left = 0;
  bit m_owner_dc = 0;
  bit m_last_dc = 1;
  bit m_w;

  function automatic bit m_win_dc();
    return dc_req_valid && (!ic_req_valid || !m_last_dc);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_phase = 0; m_left = 0; m_owner_dc = 0; m_last_dc = 1;
    end else if (m_phase == 0) begin
      if ((ic_req_valid || dc_req_valid) && mem_req_ready) begin
        m_w = m_win_dc();
        m_owner_dc = m_w;
        m_last_dc = m_w;
        m_left = 4;
        m_phase = (m_w && dc_req_rw) ? 2 : 1;
      end
    end else if ((m_phase == 1 && mem_resp_valid) ||
                 (m_phase == 2 && dc_req_data_valid && mem_req_data_ready)) begin
      m_left--;
      if (m_left == 0) m_phase = 0;
    end
  end

  // Observation logs for the literal checks.
  logic [27:0]  hs_addr[$];
  bit           hs_rw[$];
  logic [127:0] ic_q[$], dc_q[$], wr_q[$];

  logic e_idle, e_req, e_wdc, e_rd, e_wr;

  always @(negedge clk) begin
    e_idle = !reset && m_phase == 0;
    e_req  = e_idle && (ic_req_valid || dc_req_valid);
    e_wdc  = m_win_dc();
    e_rd   = !reset && m_phase == 1 && mem_resp_valid;
    e_wr   = !reset && m_phase == 2;
    check("busy", busy, !reset && m_phase != 0);
    check("mem_req_valid", mem_req_valid, e_req);
    if (e_req) begin
      check("mem_req_addr", mem_req_addr, e_wdc ? dc_req_addr : ic_req_addr);
      check("mem_req_rw", mem_req_rw, e_wdc && dc_req_rw);
    end
    check("ic_req_ready", ic_req_ready, e_req && !e_wdc && mem_req_ready);
    check("dc_req_ready", dc_req_ready, e_req && e_wdc && mem_req_ready);
    check("ic_resp_valid", ic_resp_valid, e_rd && !m_owner_dc);
    check("dc_resp_valid", dc_resp_valid, e_rd && m_owner_dc);
    if (ic_resp_valid) check("ic_resp_data", ic_resp_data, mem_resp_data);
    if (dc_resp_valid) check("dc_resp_data", dc_resp_data, mem_resp_data);
    check("mem_req_data_valid", mem_req_data_valid, e_wr && dc_req_data_valid);
    check("dc_req_data_ready", dc_req_data_ready, e_wr && mem_req_data_ready);
    if (mem_req_data_valid) begin
      check("mem_req_data_bits", mem_req_data_bits, dc_req_data_bits);
      check("mem_req_data_mask", mem_req_data_mask, dc_req_data_mask);
    end
    if (mem_req_valid && mem_req_ready) begin
      hs_addr.push_back(mem_req_addr);
      hs_rw.push_back(mem_req_rw);
      $display("txn cycle=%0d grant=%s addr=%0h rw=%0d", cyc,
               dc_req_ready ? "dc" : "ic", mem_req_addr, mem_req_rw);
    end
    if (ic_resp_valid) ic_q.push_back(ic_resp_data);
    if (dc_resp_valid) dc_q.push_back(dc_resp_data);
    if (mem_req_data_valid && mem_req_data_ready) wr_q.push_back(mem_req_data_bits);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  task automatic beats(input logic [127:0] base);
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1; mem_resp_data = base + 128'(i); step();
    end
    mem_resp_valid = 0;
  endtask

  task automatic clear_logs();
    hs_addr.delete(); hs_rw.delete(); ic_q.delete(); dc_q.delete(); wr_q.delete();
  endtask

  localparam logic [127:0] A = 128'hA0A0_0000, B = 128'hB0B0_0000, C = 128'hC0C0_0000;
  localparam logic [127:0] D = 128'hD0D0_0000, H = 128'h5050_0000, J = 128'h7070_0000;
  bit pat[5];

  initial begin
    // 1: icache read alone; request presented while still in reset.
    #1;
    ic_req_valid = 1; ic_req_addr = 28'h100; mem_req_ready = 1;
    step();
    @(negedge clk);
    check("t1_rst_ready", ic_req_ready, 0);
    check("t1_rst_memvalid", mem_req_valid, 0);
    step(); reset = 0;
    @(negedge clk);
    check("t1_ready", ic_req_ready, 1);
    step();
    ic_req_valid = 0; mem_req_ready = 0;
    beats(A);
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_hs_n", hs_addr.size(), 1);
    if (hs_addr.size() > 0) begin
      check("t1_addr", hs_addr[0], 28'h100);
      check("t1_rw", hs_rw[0], 0);
    end
    check("t1_ic_n", ic_q.size(), 4);
    for (int i = 0; i < 4 && i < ic_q.size(); i++) check("t1_ic_beat", ic_q[i], A + 128'(i));
    check("t1_dc_n", dc_q.size(), 0);

    // 2: simultaneous reads after reset, then a further tie.
    clear_logs(); do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h10;
    dc_req_valid = 1; dc_req_addr = 28'h20; dc_req_rw = 0; mem_req_ready = 1;
    step();
    ic_req_valid = 0;
    beats(B);
    @(negedge clk);
    check("t2_dc_next", dc_req_ready, 1);
    step();
    dc_req_valid = 0;
    beats(C);
    ic_req_valid = 1; ic_req_addr = 28'h30; dc_req_valid = 1; dc_req_addr = 28'h50;
    @(negedge clk);
    check("t2_tie_ic", ic_req_ready, 1);
    step();
    ic_req_valid = 0; dc_req_valid = 0; mem_req_ready = 0;
    beats(J);
    check("t2_hs_n", hs_addr.size(), 3);
    if (hs_addr.size() == 3) begin
      check("t2_order0", hs_addr[0], 28'h10);
      check("t2_order1", hs_addr[1], 28'h20);
      check("t2_order2", hs_addr[2], 28'h30);
    end
    check("t2_dc_n", dc_q.size(), 4);
    if (dc_q.size() == 4) check("t2_dc_last", dc_q[3], C + 128'd3);

    // 3: dcache write with a stalled beat; icache waits behind it.
    clear_logs();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h40;
    ic_req_valid = 1; ic_req_addr = 28'h80; mem_req_ready = 1;
    @(negedge clk);
    check("t3_dc_wins", dc_req_ready, 1);
    step();
    dc_req_valid = 0; dc_req_rw = 0;
    pat = '{1, 0, 1, 1, 1};
    begin
      int k = 0;
      for (int p = 0; p < 5; p++) begin
        dc_req_data_valid = 1; dc_req_data_bits = D + 128'(k);
        dc_req_data_mask = 16'hF0F0 ^ 16'(k); mem_req_data_ready = pat[p];
        @(negedge clk);
        check("t3_ic_blocked", ic_req_ready, 0);
        step();
        if (pat[p]) k++;
      end
    end
    dc_req_data_valid = 0; mem_req_data_ready = 0;
    @(negedge clk);
    check("t3_ic_next", ic_req_ready, 1);
    step();
    ic_req_valid = 0; mem_req_ready = 0;
    beats(B);
    check("t3_wr_n", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) check("t3_wr_beat", wr_q[i], D + 128'(i));
    check("t3_hs_n", hs_addr.size(), 2);
    if (hs_addr.size() == 2) begin
      check("t3_wr_addr", hs_addr[0], 28'h40);
      check("t3_wr_rw", hs_rw[0], 1);
      check("t3_ic_addr", hs_addr[1], 28'h80);
    end

    // 4: tie stalled by memory for three cycles (last grant was icache).
    clear_logs();
    dc_req_valid = 1; dc_req_addr = 28'h60; ic_req_valid = 1; ic_req_addr = 28'h70;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_addr", mem_req_addr, 28'h60);
      check("t4_stall_icrdy", ic_req_ready, 0);
      check("t4_stall_dcrdy", dc_req_ready, 0);
      step();
    end
    mem_req_ready = 1;
    @(negedge clk);
    check("t4_dc_rdy", dc_req_ready, 1);
    check("t4_ic_rdy", ic_req_ready, 0);
    step();
    dc_req_valid = 0; ic_req_valid = 0; mem_req_ready = 0;
    beats(C);
    check("t4_hs_n", hs_addr.size(), 1);
    check("t4_dc_n", dc_q.size(), 4);

    // 5: reset after two of four read beats.
    clear_logs(); do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h90; mem_req_ready = 1;
    step();
    ic_req_valid = 0; mem_req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1; mem_resp_data = H + 128'(i); step();
    end
    reset = 1; mem_resp_data = H + 128'd2;
    @(negedge clk);
    check("t5_rst_resp", ic_resp_valid, 0);
    step();
    reset = 0; mem_resp_data = H + 128'd3;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_stray", ic_resp_valid, 0);
    step();
    mem_resp_valid = 0;
    ic_req_valid = 1; ic_req_addr = 28'hA0; dc_req_valid = 1; dc_req_addr = 28'hB0;
    mem_req_ready = 1;
    @(negedge clk);
    check("t5_tie_ic", ic_req_ready, 1);
    step();
    ic_req_valid = 0; dc_req_valid = 0; mem_req_ready = 0;
    beats(J);
    check("t5_ic_n", ic_q.size(), 6);
    if (ic_q.size() == 6) begin
      check("t5_beat1", ic_q[1], H + 128'd1);
      check("t5_beat2", ic_q[2], J);
    end

    // 6: stray response beats while idle.
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1; mem_resp_data = A;
      @(negedge clk);
      check("t6_ic_resp", ic_resp_valid, 0);
      check("t6_dc_resp", dc_resp_valid, 0);
      check("t6_busy", busy, 0);
      step();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    check("t6_busy_end", busy, 0);
    check("t6_none", ic_q.size() + dc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
